// File: rtl/m_egress_pq.sv
// ---------------------------------------------------------------------------
// m_egress_pq
//   Store-and-forward packet queue behind the match stage. The match stage
//   has no backpressure, so every beat is absorbed here. Only complete
//   packets are released on a valid/ready output. Packets that overflow the
//   storage, or that are cut short by a new sop, are dropped whole and
//   counted.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_vld_w/sop/eop         upstream beat strobe and framing (no backpressure)
//   in_length_w/data/buffer  beat payload, stored and forwarded unchanged
//   out_vld_r, out_rdy       registered output beat, downstream ready
//   out_sop/eop/length/data/buffer_r  registered copy of the stored beat
//   level_r                  committed beats in storage (output reg excluded)
//   drop_cnt_r               packets dropped because storage was full
//   err_cnt_r                framing errors (stray beat, aborted packet)
// ---------------------------------------------------------------------------
module m_egress_pq #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int BUF_W  = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld_w,
    input  logic                     in_sop_w,
    input  logic                     in_eop_w,
    input  logic [LEN_W-1:0]         in_length_w,
    input  logic [DATA_W-1:0]        in_data_w,
    input  logic [BUF_W-1:0]         in_buffer_w,
    output logic                     out_vld_r,
    input  logic                     out_rdy,
    output logic                     out_sop_r,
    output logic                     out_eop_r,
    output logic [LEN_W-1:0]         out_length_r,
    output logic [DATA_W-1:0]        out_data_r,
    output logic [BUF_W-1:0]         out_buffer_r,
    output logic [$clog2(DEPTH):0]   level_r,
    output logic [CNT_W-1:0]         drop_cnt_r,
    output logic [CNT_W-1:0]         err_cnt_r
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + LEN_W + DATA_W + BUF_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCEPT  = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic [AW:0]      DEPTH_P = DEPTH[AW:0];
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Storage and pointers (one extra pointer bit distinguishes full/empty)
    logic [EW-1:0] r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_cm_ptr;
    logic [AW:0]   r_rd_ptr;

    logic [AW:0]   w_free;
    logic [AW:0]   w_free_cm;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [EW-1:0] w_wdata;
    logic [AW:0]   w_wr_nxt;
    logic [AW:0]   w_cm_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_err_inc;
    logic          w_drop_inc;
    logic          w_load;
    logic [AW:0]   w_rd_nxt;

    assign w_wdata = {in_sop_w, in_eop_w, in_length_w, in_data_w, in_buffer_w};

    // ------------------------------------------------------------------
    // Input side: tentative writes at wr_ptr, commit on eop by moving
    // cm_ptr. Free space is taken from registered pointers only, so a read
    // in the same cycle never makes room for a write.
    // ------------------------------------------------------------------
    always_comb begin
        w_free      = DEPTH_P - (r_wr_ptr - r_rd_ptr);
        // Space as seen after rolling back any open packet. Outside ACCEPT
        // wr_ptr already equals cm_ptr, so this is also plain free there.
        w_free_cm   = DEPTH_P - (r_cm_ptr - r_rd_ptr);
        w_we        = 1'b0;
        w_waddr     = r_wr_ptr[AW-1:0];
        w_wr_nxt    = r_wr_ptr;
        w_cm_nxt    = r_cm_ptr;
        w_state_nxt = r_state;
        w_err_inc   = 1'b0;
        w_drop_inc  = 1'b0;

        if (in_vld_w) begin
            if (in_sop_w) begin
                // A sop outside IDLE either aborts an open packet (ACCEPT)
                // or ends a discard early; both are framing errors. The new
                // packet always starts at the committed pointer.
                w_err_inc = (r_state != S_IDLE);
                if (w_free_cm != '0) begin
                    w_we     = 1'b1;
                    w_waddr  = r_cm_ptr[AW-1:0];
                    w_wr_nxt = r_cm_ptr + PTR_ONE;
                    if (in_eop_w) begin
                        w_cm_nxt    = r_cm_ptr + PTR_ONE;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ACCEPT;
                    end
                end else begin
                    w_drop_inc  = 1'b1;
                    w_wr_nxt    = r_cm_ptr;
                    w_state_nxt = in_eop_w ? S_IDLE : S_DISCARD;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_err_inc = 1'b1;
                    end
                    S_ACCEPT: begin
                        if (w_free != '0) begin
                            w_we     = 1'b1;
                            w_wr_nxt = r_wr_ptr + PTR_ONE;
                            if (in_eop_w) begin
                                w_cm_nxt    = r_wr_ptr + PTR_ONE;
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            // Out of room: roll back the whole packet.
                            w_drop_inc  = 1'b1;
                            w_wr_nxt    = r_cm_ptr;
                            w_state_nxt = in_eop_w ? S_IDLE : S_DISCARD;
                        end
                    end
                    S_DISCARD: begin
                        if (in_eop_w) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output side: load the next committed beat whenever the output
    // register is empty or being drained this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = (r_rd_ptr != r_cm_ptr) && (!out_vld_r || out_rdy);
        w_rd_nxt = w_load ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    end

    // Storage array carries no reset; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_cm_ptr     <= '0;
            r_rd_ptr     <= '0;
            out_vld_r    <= 1'b0;
            out_sop_r    <= 1'b0;
            out_eop_r    <= 1'b0;
            out_length_r <= '0;
            out_data_r   <= '0;
            out_buffer_r <= '0;
            level_r      <= '0;
            drop_cnt_r   <= '0;
            err_cnt_r    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_cm_ptr <= w_cm_nxt;
            r_rd_ptr <= w_rd_nxt;

            if (w_load) begin
                out_vld_r <= 1'b1;
                {out_sop_r, out_eop_r, out_length_r, out_data_r, out_buffer_r}
                    <= r_mem[r_rd_ptr[AW-1:0]];
            end else if (out_rdy) begin
                out_vld_r <= 1'b0;
            end

            // Built from next-state pointers so level_r always matches
            // the pointers it describes.
            level_r <= w_cm_nxt - w_rd_nxt;

            if (w_drop_inc && (drop_cnt_r != CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
            if (w_err_inc && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_m_egress_pq.sv
module tb_m_egress_pq;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int BUF_W  = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_vld_w, in_sop_w, in_eop_w;
    logic [LEN_W-1:0]        in_length_w;
    logic [DATA_W-1:0]       in_data_w;
    logic [BUF_W-1:0]        in_buffer_w;
    logic                    out_vld_r, out_rdy, out_sop_r, out_eop_r;
    logic [LEN_W-1:0]        out_length_r;
    logic [DATA_W-1:0]       out_data_r;
    logic [BUF_W-1:0]        out_buffer_r;
    logic [$clog2(DEPTH):0]  level_r;
    logic [CNT_W-1:0]        drop_cnt_r, err_cnt_r;

    always #5 clk = ~clk;

    m_egress_pq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_W(BUF_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_vld_w(in_vld_w), .in_sop_w(in_sop_w), .in_eop_w(in_eop_w),
        .in_length_w(in_length_w), .in_data_w(in_data_w), .in_buffer_w(in_buffer_w),
        .out_vld_r(out_vld_r), .out_rdy(out_rdy),
        .out_sop_r(out_sop_r), .out_eop_r(out_eop_r), .out_length_r(out_length_r),
        .out_data_r(out_data_r), .out_buffer_r(out_buffer_r),
        .level_r(level_r), .drop_cnt_r(drop_cnt_r), .err_cnt_r(err_cnt_r)
    );

    // ---------------- reference model: packets as queues ----------------
    typedef struct {
        logic              sop, eop;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
        logic [BUF_W-1:0]  bt;
    } beat_t;

    beat_t cq[$];      // committed beats not yet in the output register
    beat_t pq[$];      // beats of the packet being received
    int    mode;       // 0 between packets, 1 receiving, 2 skipping to eop
    bit    m_ovld;
    beat_t m_out;
    int    m_drop, m_err, m_level;

    always @(posedge clk) begin : model
        int    room;
        bit    ld;
        beat_t b;
        if (rst) begin
            cq.delete(); pq.delete();
            mode = 0; m_ovld = 0; m_drop = 0; m_err = 0; m_level = 0;
        end else begin
            ld     = (cq.size() > 0) && (!m_ovld || out_rdy);
            b.sop  = in_sop_w; b.eop = in_eop_w; b.len = in_length_w;
            b.data = in_data_w; b.bt = in_buffer_w;
            if (in_vld_w) begin
                if (in_sop_w) begin
                    if (mode != 0 && m_err < CMAX) m_err++;
                    pq.delete();
                    room = DEPTH - cq.size();
                    if (room > 0) begin
                        pq.push_back(b);
                        mode = 1;
                    end else begin
                        if (m_drop < CMAX) m_drop++;
                        mode = in_eop_w ? 0 : 2;
                    end
                end else if (mode == 0) begin
                    if (m_err < CMAX) m_err++;
                end else if (mode == 1) begin
                    room = DEPTH - cq.size() - pq.size();
                    if (room > 0) begin
                        pq.push_back(b);
                    end else begin
                        pq.delete();
                        if (m_drop < CMAX) m_drop++;
                        mode = in_eop_w ? 0 : 2;
                    end
                end else if (in_eop_w) begin
                    mode = 0;
                end
                // a packet that survived up to its eop is released whole
                if (mode == 1 && in_eop_w) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                    mode = 0;
                end
            end
            if (ld) begin
                m_out  = cq.pop_front();
                m_ovld = 1;
            end else if (out_rdy) begin
                m_ovld = 0;
            end
            m_level = cq.size();
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [DATA_W-1:0] rx[$];
    int                rx_cyc[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_model();
        chk("mdl_vld", 64'(out_vld_r), 64'(m_ovld));
        if (m_ovld) begin
            chk("mdl_data", 64'(out_data_r), 64'(m_out.data));
            chk("mdl_buf",  64'(out_buffer_r), 64'(m_out.bt));
            chk("mdl_len",  64'(out_length_r), 64'(m_out.len));
            chk("mdl_sop",  64'(out_sop_r), 64'(m_out.sop));
            chk("mdl_eop",  64'(out_eop_r), 64'(m_out.eop));
        end
        chk("mdl_level", 64'(level_r), 64'(m_level));
        chk("mdl_drop",  64'(drop_cnt_r), 64'(m_drop));
        chk("mdl_err",   64'(err_cnt_r), 64'(m_err));
    endtask

    task automatic drive(input bit v, input bit s, input bit e,
                         input logic [DATA_W-1:0] d, input logic [BUF_W-1:0] b);
        in_vld_w    = v;
        in_sop_w    = s;
        in_eop_w    = e;
        in_data_w   = d;
        in_buffer_w = b;
        in_length_w = d[15:0] ^ 16'h0f0f;
    endtask

    task automatic tick();
        if (out_vld_r && out_rdy) begin
            rx.push_back(out_data_r);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        cmp_model();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_pkt(input int n, input logic [DATA_W-1:0] base, input logic [BUF_W-1:0] b);
        for (int i = 0; i < n; i++) begin
            drive(1, i == 0, i == n - 1, base + DATA_W'(i), b);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        tick();
        rst = 1'b0;
        rx.delete(); rx_cyc.delete();
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, 64'(rx.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk({name, "_beat"}, 64'(rx[i]), 64'(exp_q[i]));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit                vld, sop, eop, rdy;
        logic [DATA_W-1:0] data;
        logic [BUF_W-1:0]  bt;
        bit                e_vld;
        logic [DATA_W-1:0] e_data;
        logic [BUF_W-1:0]  e_bt;
        int                e_level, e_err;
    } vec_t;

    vec_t tv[8];

    initial begin
        int rem;
        rst = 1'b1;
        out_rdy = 1'b1;
        drive(0, 0, 0, '0, '0);

        // vld sop eop rdy data bt | e_vld e_data e_bt e_level e_err
        tv[0] = '{1, 1, 1, 1, 32'hA5, 4'd3, 0, 32'h0,  4'd0, 1, 0}; // single-beat packet
        tv[1] = '{0, 0, 0, 1, 32'h0,  4'd0, 1, 32'hA5, 4'd3, 0, 0}; // out one edge after eop
        tv[2] = '{0, 0, 0, 1, 32'h0,  4'd0, 0, 32'h0,  4'd0, 0, 0}; // single cycle only
        tv[3] = '{1, 0, 0, 1, 32'h11, 4'd1, 0, 32'h0,  4'd0, 0, 1}; // stray beat
        tv[4] = '{1, 1, 0, 1, 32'h22, 4'd2, 0, 32'h0,  4'd0, 0, 1}; // open a packet
        tv[5] = '{1, 1, 1, 1, 32'h33, 4'd5, 0, 32'h0,  4'd0, 1, 2}; // abort + new single
        tv[6] = '{0, 0, 0, 1, 32'h0,  4'd0, 1, 32'h33, 4'd5, 0, 2};
        tv[7] = '{0, 0, 0, 1, 32'h0,  4'd0, 0, 32'h0,  4'd0, 0, 2};

        do_reset();
        chk("rst_vld",   64'(out_vld_r), 64'd0);
        chk("rst_data",  64'(out_data_r), 64'd0);
        chk("rst_level", 64'(level_r), 64'd0);
        chk("rst_drop",  64'(drop_cnt_r), 64'd0);
        chk("rst_err",   64'(err_cnt_r), 64'd0);

        for (int i = 0; i < 8; i++) begin
            out_rdy = tv[i].rdy;
            drive(tv[i].vld, tv[i].sop, tv[i].eop, tv[i].data, tv[i].bt);
            tick();
            chk("tv_vld", 64'(out_vld_r), 64'(tv[i].e_vld));
            if (tv[i].e_vld) begin
                chk("tv_data", 64'(out_data_r), 64'(tv[i].e_data));
                chk("tv_buf",  64'(out_buffer_r), 64'(tv[i].e_bt));
                chk("tv_sop",  64'(out_sop_r), 64'd1);
                chk("tv_eop",  64'(out_eop_r), 64'd1);
            end
            chk("tv_level", 64'(level_r), 64'(tv[i].e_level));
            chk("tv_err",   64'(err_cnt_r), 64'(tv[i].e_err));
        end

        // Two back-to-back 4-beat packets: 8 contiguous beats in order
        do_reset();
        out_rdy = 1'b1;
        send_pkt(4, 32'h1000, 4'd1);
        send_pkt(4, 32'h2000, 4'd2);
        idle(8);
        exp_q = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h2000, 32'h2001, 32'h2002, 32'h2003};
        check_rx("b2b");
        if (rx_cyc.size() == 8) chk("b2b_contig", 64'(rx_cyc[7] - rx_cyc[0]), 64'd7);
        else chk("b2b_contig_count", 64'(rx_cyc.size()), 64'd8);
        chk("b2b_level", 64'(level_r), 64'd0);

        // Oversize packet dropped, following packet intact
        do_reset();
        out_rdy = 1'b0;
        send_pkt(20, 32'h3000, 4'd4);
        chk("big_vld", 64'(out_vld_r), 64'd0);
        send_pkt(3, 32'h4000, 4'd6);
        idle(2);
        chk("big_drop", 64'(drop_cnt_r), 64'd1);
        out_rdy = 1'b1;
        idle(6);
        exp_q = '{32'h4000, 32'h4001, 32'h4002};
        check_rx("big");

        // Unterminated packet aborted by a new sop
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, 0, 32'h5000 + DATA_W'(i), 4'd7);
            tick();
        end
        send_pkt(2, 32'h6000, 4'd8);
        idle(5);
        chk("abort_err", 64'(err_cnt_r), 64'd1);
        exp_q = '{32'h6000, 32'h6001};
        check_rx("abort");

        // Output stall with ready pattern 1,0,0,1
        do_reset();
        out_rdy = 1'b1;
        send_pkt(4, 32'h7000, 4'd9);
        drive(0, 0, 0, '0, '0);
        tick();                       // first beat now in the output register
        out_rdy = 1'b1; tick();
        out_rdy = 1'b0; tick();
        chk("stall_hold_a", 64'(out_data_r), 64'h7001);
        out_rdy = 1'b0; tick();
        chk("stall_hold_b", 64'(out_data_r), 64'h7001);
        out_rdy = 1'b1;
        idle(5);
        exp_q = '{32'h7000, 32'h7001, 32'h7002, 32'h7003};
        check_rx("stall");

        // Reset mid-packet with committed data in storage
        do_reset();
        out_rdy = 1'b0;
        drive(1, 0, 0, 32'h1, 4'd0); tick();   // stray beat -> err
        send_pkt(5, 32'h8000, 4'd10);
        drive(1, 1, 0, 32'h9000, 4'd11); tick();
        drive(1, 0, 0, 32'h9001, 4'd11); tick();
        chk("pre_rst_level", 64'(level_r), 64'd4);
        rst = 1'b1;
        drive(1, 0, 0, 32'h9002, 4'd11);
        tick();
        rst = 1'b0;
        chk("mid_rst_vld",   64'(out_vld_r), 64'd0);
        chk("mid_rst_level", 64'(level_r), 64'd0);
        chk("mid_rst_drop",  64'(drop_cnt_r), 64'd0);
        chk("mid_rst_err",   64'(err_cnt_r), 64'd0);
        rx.delete(); rx_cyc.delete();
        out_rdy = 1'b1;
        send_pkt(2, 32'hA000, 4'd12);
        idle(5);
        exp_q = '{32'hA000, 32'hA001};
        check_rx("post_rst");

        // Randomised traffic against the model
        do_reset();
        rem = 0;
        for (int c = 0; c < 3000; c++) begin
            out_rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                bit s;
                s = 1'b0;
                if (rem == 0) begin
                    if ($urandom_range(0, 29) != 0) s = 1'b1;   // else stray beat
                end else if ($urandom_range(0, 24) == 0) begin
                    s = 1'b1;                                    // abort open packet
                end
                if (s) rem = $urandom_range(1, 20);
                drive(1, s, rem == 1, $urandom(), 4'($urandom_range(0, 15)));
                if (rem > 0) rem--;
            end else begin
                drive(0, 0, 0, $urandom(), '0);
            end
            tick();
        end
        out_rdy = 1'b1;
        idle(24);
        chk("rand_drain_level", 64'(level_r), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
